// File: rtl/pwr_mon_pkg.sv
// pwr_mon_pkg: shared state encoding and violation indices for the power-domain monitor.
package pwr_mon_pkg;

    typedef enum logic [2:0] {
        S_ON      = 3'd0,
        S_SAVE    = 3'd1,
        S_ISO     = 3'd2,
        S_OFF     = 3'd3,
        S_PWRUP   = 3'd4,
        S_RESTORE = 3'd5
    } pwr_state_t;

    localparam int V_NOSAVE    = 0;
    localparam int V_ISO_DROP  = 1;
    localparam int V_NORESTORE = 2;
    localparam int V_ISO_EARLY = 3;
    localparam int NUM_VIOL    = 4;

endpackage

// File: rtl/pwr_domain_tracker.sv
// pwr_domain_tracker: per-domain save/isolate/off/power-up/restore sequence FSM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pwr_en       : power switch enable
//   iso_en       : isolation enable
//   save         : retention save request
//   restore      : retention restore request
//   state        : current FSM state
//   ev           : single-cycle violation pulses for this cycle's inputs, indexed by V_*
module pwr_domain_tracker
    import pwr_mon_pkg::*;
#(
    parameter int RESTORE_WIN = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwr_en,
    input  logic                iso_en,
    input  logic                save,
    input  logic                restore,
    output logic [2:0]          state,
    output logic [NUM_VIOL-1:0] ev
);

    localparam int CW = $clog2(RESTORE_WIN + 1);

    pwr_state_t st, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic pwr_en_q, iso_en_q, isodrop_q;
    logic pwr_fall, iso_fall, isodrop;

    assign state    = st;
    assign pwr_fall = pwr_en_q & ~pwr_en;
    assign iso_fall = iso_en_q & ~iso_en;
    assign isodrop  = ~pwr_en & ~iso_en;

    always_comb begin
        nxt   = st;
        cnt_n = cnt;
        ev    = '0;
        ev[V_ISO_DROP] = isodrop & ~isodrop_q;
        case (st)
            S_ON:
                if (pwr_fall) begin
                    nxt = S_OFF;
                    ev[V_NOSAVE] = 1'b1;
                end else if (save) nxt = S_SAVE;
            S_SAVE:
                if (pwr_fall) begin
                    nxt = S_OFF;
                    ev[V_NOSAVE] = 1'b1;
                end else if (~save) nxt = iso_en ? S_ISO : S_ON;
            S_ISO:
                if (~pwr_en) nxt = S_OFF;
                else if (~iso_en) nxt = S_ON;
            S_OFF:
                if (pwr_en) begin
                    nxt   = S_PWRUP;
                    cnt_n = '0;
                end
            S_PWRUP:
                // An early isolation drop holds the window count for that cycle.
                if (restore) nxt = S_RESTORE;
                else if (iso_fall) ev[V_ISO_EARLY] = 1'b1;
                else if (cnt == CW'(RESTORE_WIN - 1)) begin
                    nxt = S_ON;
                    ev[V_NORESTORE] = 1'b1;
                end else if (pwr_fall) nxt = S_OFF;
                else cnt_n = cnt + 1'b1;
            S_RESTORE:
                if (~restore & ~iso_en) nxt = S_ON;
            default: nxt = S_ON;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_ON;
            cnt       <= '0;
            pwr_en_q  <= 1'b1;
            iso_en_q  <= 1'b0;
            isodrop_q <= 1'b0;
        end else begin
            st        <= nxt;
            cnt       <= cnt_n;
            pwr_en_q  <= pwr_en;
            iso_en_q  <= iso_en;
            isodrop_q <= isodrop;
        end
    end

endmodule

// File: rtl/multi_domain_power_monitor.sv
// multi_domain_power_monitor: sequencing monitor for NUM_DOMAINS switched power domains.
//   clk, rst_n  : clock, asynchronous active-low reset
//   pwr_en, iso_en, save, restore : per-domain power controller signals
//   clear       : synchronous clear of sticky flags, counter and first-error capture
//   state_o     : per-domain FSM state, 3 bits per domain
//   viol_sticky : per-domain sticky violation flags, 4 bits per domain
//   viol_cnt    : saturating count of violation events
//   first_valid, first_dom, first_code : first captured violation
//   irq         : registered OR of all sticky flags
module multi_domain_power_monitor
    import pwr_mon_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int RESTORE_WIN = 10,
    parameter int CNT_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_DOMAINS-1:0]          pwr_en,
    input  logic [NUM_DOMAINS-1:0]          iso_en,
    input  logic [NUM_DOMAINS-1:0]          save,
    input  logic [NUM_DOMAINS-1:0]          restore,
    input  logic                            clear,
    output logic [3*NUM_DOMAINS-1:0]        state_o,
    output logic [NUM_VIOL*NUM_DOMAINS-1:0] viol_sticky,
    output logic [CNT_W-1:0]                viol_cnt,
    output logic                            first_valid,
    output logic [3:0]                      first_dom,
    output logic [1:0]                      first_code,
    output logic                            irq
);

    localparam int NE = NUM_VIOL * NUM_DOMAINS;
    localparam int SW = CNT_W + 7;

    logic [NE-1:0]    ev;
    logic [6:0]       pc;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_n;
    logic             hit;
    logic [3:0]       hit_dom;
    logic [1:0]       hit_code;

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        pwr_domain_tracker #(.RESTORE_WIN(RESTORE_WIN)) u_trk (
            .clk     (clk),
            .rst_n   (rst_n),
            .pwr_en  (pwr_en[g]),
            .iso_en  (iso_en[g]),
            .save    (save[g]),
            .restore (restore[g]),
            .state   (state_o[3*g +: 3]),
            .ev      (ev[NUM_VIOL*g +: NUM_VIOL])
        );
    end

    // Count is widened before the add so saturation never sees a wrapped value.
    always_comb begin
        pc = '0;
        for (int i = 0; i < NE; i++) pc = pc + 7'(ev[i]);
        sum   = {7'd0, clear ? {CNT_W{1'b0}} : viol_cnt} + {{CNT_W{1'b0}}, pc};
        cnt_n = sum > SW'({CNT_W{1'b1}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Scan high to low so the lowest domain, then lowest violation index, wins.
    always_comb begin
        hit      = 1'b0;
        hit_dom  = '0;
        hit_code = '0;
        for (int d = NUM_DOMAINS - 1; d >= 0; d--)
            for (int v = NUM_VIOL - 1; v >= 0; v--)
                if (ev[NUM_VIOL*d + v]) begin
                    hit      = 1'b1;
                    hit_dom  = 4'(d);
                    hit_code = 2'(v);
                end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_sticky <= '0;
            viol_cnt    <= '0;
            first_valid <= 1'b0;
            first_dom   <= '0;
            first_code  <= '0;
            irq         <= 1'b0;
        end else begin
            viol_sticky <= (clear ? '0 : viol_sticky) | ev;
            viol_cnt    <= cnt_n;
            irq         <= |viol_sticky;
            if (hit && (clear || !first_valid)) begin
                first_valid <= 1'b1;
                first_dom   <= hit_dom;
                first_code  <= hit_code;
            end else if (clear) first_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_domain_power_monitor.sv
// tb_multi_domain_power_monitor: directed vector bench for the power-domain monitor.
module tb_multi_domain_power_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pwr_en, iso_en, save, restore;
    logic        clear;
    logic [11:0] state_o;
    logic [15:0] viol_sticky;
    logic [1:0]  viol_cnt;
    logic        first_valid, irq;
    logic [3:0]  first_dom;
    logic [1:0]  first_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  pwr, iso, sv, rs;
        logic        clr;
        logic [11:0] st;
        logic [15:0] stk;
        logic [1:0]  cnt;
        logic        fv;
        logic [3:0]  fd;
        logic [1:0]  fc;
        logic        irq;
    } vec_t;

    vec_t tv[$];

    multi_domain_power_monitor #(.NUM_DOMAINS(4), .RESTORE_WIN(10), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwr_en      (pwr_en),
        .iso_en      (iso_en),
        .save        (save),
        .restore     (restore),
        .clear       (clear),
        .state_o     (state_o),
        .viol_sticky (viol_sticky),
        .viol_cnt    (viol_cnt),
        .first_valid (first_valid),
        .first_dom   (first_dom),
        .first_code  (first_code),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " state"}, 32'(state_o), 0);
        chk({nm, " sticky"}, 32'(viol_sticky), 0);
        chk({nm, " cnt"}, 32'(viol_cnt), 0);
        chk({nm, " fv"}, 32'(first_valid), 0);
        chk({nm, " irq"}, 32'(irq), 0);
    endtask

    task automatic to_pwrup(input int d);
        save[d] = 1'b1;
        step;
        save[d] = 1'b0;
        iso_en[d] = 1'b1;
        step;
        pwr_en[d] = 1'b0;
        step;
        pwr_en[d] = 1'b1;
        step;
    endtask

    initial begin
        // legal cycle on domain 0
        tv.push_back('{4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 12'h001, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 12'h001, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 12'h002, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 12'h004, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 12'h004, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 12'h004, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h1, 4'h0, 4'h1, 1'b0, 12'h005, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        // missing save on domain 2, isolation held so only V_NOSAVE fires
        tv.push_back('{4'hB, 4'h4, 4'h0, 4'h0, 1'b0, 12'h0C0, 16'h0100, 2'd1, 1'b1, 4'd2, 2'd0, 1'b0});
        tv.push_back('{4'hB, 4'h4, 4'h0, 4'h0, 1'b0, 12'h0C0, 16'h0100, 2'd1, 1'b1, 4'd2, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h4, 4'h0, 4'h0, 1'b0, 12'h100, 16'h0100, 2'd1, 1'b1, 4'd2, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h4, 4'h0, 4'h4, 1'b0, 12'h140, 16'h0100, 2'd1, 1'b1, 4'd2, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 16'h0100, 2'd1, 1'b1, 4'd2, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 12'h000, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        // simultaneous drops on domains 1 and 3
        tv.push_back('{4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 12'h618, 16'h1010, 2'd2, 1'b1, 4'd1, 2'd0, 1'b0});
        tv.push_back('{4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 12'h618, 16'h1010, 2'd2, 1'b1, 4'd1, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'hA, 4'h0, 4'h0, 1'b0, 12'h820, 16'h1010, 2'd2, 1'b1, 4'd1, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'hA, 4'h0, 4'hA, 1'b0, 12'hA28, 16'h1010, 2'd2, 1'b1, 4'd1, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 16'h1010, 2'd2, 1'b1, 4'd1, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 12'h000, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b1});
        tv.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        // domain 0 to OFF legally, then five isolation drops while off
        tv.push_back('{4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 12'h001, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hF, 4'h1, 4'h0, 4'h0, 1'b0, 12'h002, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0000, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0});
        tv.push_back('{4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd1, 1'b1, 4'd0, 2'd1, 1'b0});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd1, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd2, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd2, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd3, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd3, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd3, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd3, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd3, 1'b1, 4'd0, 2'd1, 1'b1});
        tv.push_back('{4'hE, 4'h1, 4'h0, 4'h0, 1'b0, 12'h003, 16'h0002, 2'd3, 1'b1, 4'd0, 2'd1, 1'b1});
        // clear together with a new domain-3 event: the event survives the clear
        tv.push_back('{4'h6, 4'h9, 4'h0, 4'h0, 1'b1, 12'h603, 16'h1000, 2'd1, 1'b1, 4'd3, 2'd0, 1'b1});
        tv.push_back('{4'h6, 4'h9, 4'h0, 4'h0, 1'b0, 12'h603, 16'h1000, 2'd1, 1'b1, 4'd3, 2'd0, 1'b1});

        rst_n = 1'b0;
        pwr_en = 4'hF; iso_en = 4'h0; save = 4'h0; restore = 4'h0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset fdom", 32'(first_dom), 0);
        chk("reset fcode", 32'(first_code), 0);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            pwr_en = tv[i].pwr; iso_en = tv[i].iso; save = tv[i].sv;
            restore = tv[i].rs; clear = tv[i].clr;
            step;
            chk($sformatf("v%0d state", i), 32'(state_o), 32'(tv[i].st));
            chk($sformatf("v%0d sticky", i), 32'(viol_sticky), 32'(tv[i].stk));
            chk($sformatf("v%0d cnt", i), 32'(viol_cnt), 32'(tv[i].cnt));
            chk($sformatf("v%0d fv", i), 32'(first_valid), 32'(tv[i].fv));
            chk($sformatf("v%0d irq", i), 32'(irq), 32'(tv[i].irq));
            if (tv[i].fv) begin
                chk($sformatf("v%0d fdom", i), 32'(first_dom), 32'(tv[i].fd));
                chk($sformatf("v%0d fcode", i), 32'(first_code), 32'(tv[i].fc));
            end
        end
        clear = 1'b0;

        // reset while domains 0 and 3 sit in PWRUP
        pwr_en = 4'hF;
        step;
        chk("pre-reset d0 pwrup", 32'(state_o[2:0]), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        pwr_en = 4'hF; iso_en = 4'h0; save = 4'h0; restore = 4'h0;
        step;
        rst_n = 1'b1;
        repeat (3) step;
        chk_idle("post reset");

        // restore timeout on domain 1
        to_pwrup(1);
        chk("to d1 pwrup", 32'(state_o[5:3]), 4);
        repeat (9) step;
        chk("to edge9 state", 32'(state_o[5:3]), 4);
        chk("to edge9 sticky", 32'(viol_sticky), 0);
        step;
        chk("to edge10 state", 32'(state_o[5:3]), 0);
        chk("to edge10 sticky", 32'(viol_sticky), 16'h0040);
        chk("to edge10 cnt", 32'(viol_cnt), 1);
        chk("to edge10 fdom", 32'(first_dom), 1);
        chk("to edge10 fcode", 32'(first_code), 2);
        iso_en[1] = 1'b0;
        clear = 1'b1;
        step;
        clear = 1'b0;
        chk("to clear cnt", 32'(viol_cnt), 0);
        chk("to clear fv", 32'(first_valid), 0);

        // restore sampled exactly on the last window edge
        to_pwrup(1);
        repeat (9) step;
        restore[1] = 1'b1;
        step;
        chk("rw edge10 state", 32'(state_o[5:3]), 5);
        chk("rw edge10 sticky", 32'(viol_sticky), 0);
        chk("rw edge10 cnt", 32'(viol_cnt), 0);
        restore[1] = 1'b0;
        iso_en[1] = 1'b0;
        step;
        chk("rw exit state", 32'(state_o), 0);
        chk("rw exit sticky", 32'(viol_sticky), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
